// File: rtl/ps2_host_transmitter_if.sv
// Byte-level handshake between a client and the PS/2 host transmitter.
// The client offers a byte with a one-cycle start strobe while ready is high.
// The transmitter answers each frame with exactly one done or error pulse.
interface ps2_host_transmitter_if;
    logic [7:0] txData;
    logic       txStart;
    logic       txReady;
    logic       txDone;
    logic       txError;

    modport master (
        output txData,
        output txStart,
        input  txReady,
        input  txDone,
        input  txError
    );

    modport slave (
        input  txData,
        input  txStart,
        output txReady,
        output txDone,
        output txError
    );
endinterface

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter.
// Sends one byte as an 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
// The host first inhibits the bus, then issues request-to-send, and finally shifts
// bits on the device-generated falling clock edges. The device's acknowledge is
// sampled on the 11th falling edge. One watchdog covers everything from the clock
// release to the final bus-idle check.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ps2_host_transmitter_if.slave  tx,
    input  logic                   ps2ClkIn,
    input  logic                   ps2DataIn,
    output logic                   ps2ClkOe,
    output logic                   ps2DataOe
);

    // Each counter only needs to hold its terminal value minus one.
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [1:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic               r_clk_prev;
    logic [8:0]         r_frame;       // {parity, data}
    logic [3:0]         r_bit_idx;
    logic               r_bit_oe;      // data-line pull for the bit currently on the wire
    logic [INH_W-1:0]   r_inh_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_tx_done;
    logic               r_tx_error;

    logic               w_fall;
    logic               w_inh_last;
    logic               w_frame_active;
    logic               w_timeout;
    logic               w_done_next;
    logic               w_error_next;
    logic               w_clk_oe;
    logic               w_data_oe;

    assign w_fall         = r_clk_prev & ~r_clk_sync[1];
    assign w_inh_last     = (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
    assign w_frame_active = (r_state == S_RTS)   || (r_state == S_SHIFT) ||
                            (r_state == S_STOP)  || (r_state == S_ACK)   ||
                            (r_state == S_WAIT_IDLE);
    assign w_timeout      = w_frame_active && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Bring the open-collector bus lines into the clk domain; idle bus reads as 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            r_clk_sync  <= {r_clk_sync[0], ps2ClkIn};
            r_data_sync <= {r_data_sync[0], ps2DataIn};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    // State register plus the registered one-cycle result pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tx_done  <= w_done_next;
            r_tx_error <= w_error_next;
        end
    end

    // Next-state decode and bus-drive outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_error_next = 1'b0;
        w_clk_oe     = 1'b0;
        w_data_oe    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (tx.txStart) w_state_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                // Host owns the clock here, so device edges are not looked at.
                w_clk_oe = 1'b1;
                if (w_inh_last) begin
                    w_data_oe    = 1'b1;   // start bit goes out before clock release
                    w_state_next = S_RTS;
                end
            end
            S_RTS: begin
                w_data_oe = 1'b1;
                if (w_fall) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                w_data_oe = r_bit_oe;
                // Edge that loads the parity bit moves on to the stop bit.
                if (w_fall && (r_bit_idx == 4'd8)) w_state_next = S_STOP;
            end
            S_STOP: begin
                w_data_oe = r_bit_oe;
                if (w_fall) w_state_next = S_ACK;
            end
            S_ACK: begin
                if (w_fall) begin
                    if (r_data_sync[1]) begin
                        w_error_next = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_sync[1] && r_data_sync[1]) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Watchdog overrides everything, including a simultaneous ack or idle.
        if (w_timeout) begin
            w_done_next  = 1'b0;
            w_error_next = 1'b1;
            w_state_next = S_IDLE;
        end
    end

    // Frame capture, bit sequencing and the two cycle counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame   <= '0;
            r_bit_idx <= '0;
            r_bit_oe  <= 1'b0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if ((r_state == S_IDLE) && tx.txStart) begin
                r_frame <= {~^tx.txData, tx.txData};
            end

            if ((r_state == S_INHIBIT) && !w_inh_last) r_inh_cnt <= r_inh_cnt + 1'b1;
            else                                       r_inh_cnt <= '0;

            if (w_frame_active && !w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
            else                              r_to_cnt <= '0;

            unique case (r_state)
                S_RTS: begin
                    if (w_fall) begin
                        r_bit_oe  <= ~r_frame[0];
                        r_bit_idx <= 4'd1;
                    end
                end
                S_SHIFT: begin
                    if (w_fall) begin
                        r_bit_oe  <= ~r_frame[r_bit_idx];
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_fall) r_bit_oe <= 1'b0;   // release data: stop bit reads 1
                end
                S_IDLE: begin
                    r_bit_idx <= '0;
                    r_bit_oe  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign tx.txReady = (r_state == S_IDLE);
    assign tx.txDone  = r_tx_done;
    assign tx.txError = r_tx_error;
    assign ps2ClkOe   = w_clk_oe;
    assign ps2DataOe  = w_data_oe;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Testbench for ps2_host_transmitter: a behavioural PS/2 device clocks frames out
// of the host, and each wire bit is compared against a queue of expected bits
// pushed when the byte was offered. Frame outcomes use a second queue.
module tb_ps2_host_transmitter;

    localparam int INH  = 20;
    localparam int TO   = 2000;
    localparam int HALF = 12;      // device clock half period in clk cycles

    logic clk = 1'b0;
    logic reset_n;
    logic clk_oe, data_oe;
    logic dev_clk_low, dev_data_low;
    logic ps2_clk_line, ps2_data_line;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   snap_done, snap_err;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    logic exp_bits[$];
    int   exp_outcome[$];      // 1 = done, 2 = error

    always #5 clk = ~clk;

    // Open-collector bus: either side pulling low wins.
    assign ps2_clk_line  = ~(clk_oe  | dev_clk_low);
    assign ps2_data_line = ~(data_oe | dev_data_low);

    ps2_host_transmitter_if tx_if ();

    ps2_host_transmitter #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx        (tx_if),
        .ps2ClkIn  (ps2_clk_line),
        .ps2DataIn (ps2_data_line),
        .ps2ClkOe  (clk_oe),
        .ps2DataOe (data_oe)
    );

    // Pulse monitor: counts results and checks exclusivity and single-cycle width.
    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_if.txDone)  done_cnt++;
            if (tx_if.txError) err_cnt++;
            if (tx_if.txDone || tx_if.txError) begin
                n_checks++;
                if ((tx_if.txDone && tx_if.txError) || (tx_if.txDone && prev_done) ||
                    (tx_if.txError && prev_err)) begin
                    n_fail++;
                    $display("FAIL pulse_shape: done=%0b error=%0b prev_done=%0b prev_error=%0b, required single exclusive pulse",
                             tx_if.txDone, tx_if.txError, prev_done, prev_err);
                end
            end
        end
        prev_done = tx_if.txDone;
        prev_err  = tx_if.txError;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        tx_if.txData     = 8'h00;
        tx_if.txStart    = 1'b0;
        dev_clk_low      = 1'b0;
        dev_data_low     = 1'b0;
        repeat (3) tick();
        n_checks += 5;
        if (tx_if.txReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_if.txReady); end
        if (tx_if.txDone  !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_if.txDone); end
        if (tx_if.txError !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", tx_if.txError); end
        if (clk_oe        !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b want 0", clk_oe); end
        if (data_oe       !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", data_oe); end
        reset_n = 1'b1;
        repeat (5) tick();
    endtask

    // Offer a byte and push the frame the device should see plus the outcome.
    task automatic start_tx(input logic [7:0] d, input bit ack);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        exp_bits.push_back(1'b1);
        exp_outcome.push_back(ack ? 1 : 2);
        snap_done = done_cnt;
        snap_err  = err_cnt;
        n_checks++;
        if (tx_if.txReady !== 1'b1) begin n_fail++; $display("FAIL ready_before_start: got %b want 1", tx_if.txReady); end
        tx_if.txData  = d;
        tx_if.txStart = 1'b1;
        tick();
        tx_if.txStart = 1'b0;
    endtask

    // Behavioural device: checks inhibit/RTS, then clocks 11 edges sampling each bit.
    task automatic device_frame(input bit ack, input int inject_k, input int abort_k, output bit aborted);
        int   n, inh, dcnt, dlast;
        logic exp;
        aborted = 1'b0;
        n = 0;
        while (!clk_oe && n < 100) begin tick(); n++; end
        inh = 0; dcnt = 0; dlast = -1;
        while (clk_oe && inh < INH + 100) begin
            if (data_oe) begin dcnt++; dlast = inh; end
            inh++;
            tick();
        end
        n_checks += 4;
        if (inh !== INH) begin n_fail++; $display("FAIL inhibit_len: got %0d want %0d", inh, INH); end
        if (dcnt !== 1) begin n_fail++; $display("FAIL inhibit_start_cycles: got %0d want 1", dcnt); end
        if (dlast !== INH - 1) begin n_fail++; $display("FAIL inhibit_start_pos: got %0d want %0d", dlast, INH - 1); end
        if (data_oe !== 1'b1) begin n_fail++; $display("FAIL rts_data_oe: got %b want 1", data_oe); end
        repeat (6) tick();
        exp = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'bx;
        n_checks++;
        if (ps2_data_line !== exp) begin n_fail++; $display("FAIL start_bit: got %b want %b", ps2_data_line, exp); end

        for (int k = 1; k <= 11; k++) begin
            if (k == inject_k) begin
                n_checks++;
                if (tx_if.txReady !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", tx_if.txReady); end
                tx_if.txData  = 8'h5A;
                tx_if.txStart = 1'b1;
                tick();
                tx_if.txStart = 1'b0;
            end
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (2) tick();
            end
            dev_clk_low = 1'b1;
            if (k == abort_k) begin
                repeat (3) tick();
                n_checks++;
                if (data_oe !== 1'b1) begin n_fail++; $display("FAIL pre_abort_data_oe: got %b want 1", data_oe); end
                #2 reset_n = 1'b0;
                #1;
                n_checks += 3;
                if (clk_oe  !== 1'b0) begin n_fail++; $display("FAIL abort_clk_oe: got %b want 0", clk_oe); end
                if (data_oe !== 1'b0) begin n_fail++; $display("FAIL abort_data_oe: got %b want 0", data_oe); end
                if (tx_if.txReady !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", tx_if.txReady); end
                dev_clk_low = 1'b0;
                aborted = 1'b1;
                return;
            end
            repeat (HALF) tick();
            if (k <= 10) begin
                exp = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'bx;
                n_checks++;
                if (ps2_data_line !== exp) begin
                    n_fail++;
                    $display("FAIL wire_bit_%0d: got %b want %b", k, ps2_data_line, exp);
                end
            end
            dev_clk_low = 1'b0;
            repeat (HALF) tick();
            if (k == 11) dev_data_low = 1'b0;
        end
    endtask

    // Wait (bounded) for the frame result and compare with the scoreboard.
    task automatic wait_outcome(input string name);
        int got, want, n;
        n = 0;
        while ((done_cnt == snap_done) && (err_cnt == snap_err) && n < 300) begin tick(); n++; end
        repeat (20) tick();
        if ((done_cnt - snap_done == 1) && (err_cnt == snap_err))      got = 1;
        else if ((err_cnt - snap_err == 1) && (done_cnt == snap_done)) got = 2;
        else                                                           got = 0;
        want = (exp_outcome.size() > 0) ? exp_outcome.pop_front() : -1;
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s_outcome: got %0d (done+%0d err+%0d) want %0d", name, got,
                     done_cnt - snap_done, err_cnt - snap_err, want);
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input string name);
        bit ab;
        start_tx(d, 1'b1);
        device_frame(1'b1, 0, 0, ab);
        wait_outcome(name);
    endtask

    task automatic test_no_ack();
        bit ab;
        start_tx(8'h3C, 1'b0);
        device_frame(1'b0, 0, 0, ab);
        wait_outcome("no_ack");
    endtask

    task automatic test_timeout();
        int n, cnt;
        snap_done = done_cnt;
        n_checks++;
        if (tx_if.txReady !== 1'b1) begin n_fail++; $display("FAIL timeout_ready_before: got %b want 1", tx_if.txReady); end
        tx_if.txData  = 8'h77;
        tx_if.txStart = 1'b1;
        tick();
        tx_if.txStart = 1'b0;
        n = 0;
        while (!clk_oe && n < 100) begin tick(); n++; end
        n = 0;
        while (clk_oe && n < INH + 100) begin tick(); n++; end
        cnt = 0;
        while (!tx_if.txError && cnt < TO + 100) begin tick(); cnt++; end
        n_checks += 5;
        if (cnt !== TO) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", cnt, TO); end
        if (clk_oe !== 1'b0) begin n_fail++; $display("FAIL timeout_clk_oe: got %b want 0", clk_oe); end
        if (data_oe !== 1'b0) begin n_fail++; $display("FAIL timeout_data_oe: got %b want 0", data_oe); end
        if (tx_if.txReady !== 1'b1) begin n_fail++; $display("FAIL timeout_ready: got %b want 1", tx_if.txReady); end
        if (done_cnt !== snap_done) begin n_fail++; $display("FAIL timeout_done: got %0d extra want 0", done_cnt - snap_done); end
        tick();
        n_checks++;
        if (tx_if.txError !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b want 0", tx_if.txError); end
        repeat (10) tick();
    endtask

    task automatic test_ignore_start();
        bit ab;
        start_tx(8'h96, 1'b1);
        device_frame(1'b1, 5, 0, ab);
        wait_outcome("ignore_start");
    endtask

    task automatic test_reset_mid();
        bit ab;
        int d0, e0;
        start_tx(8'h00, 1'b1);
        device_frame(1'b1, 0, 4, ab);
        n_checks++;
        if (ab !== 1'b1) begin n_fail++; $display("FAIL abort_reached: got %b want 1", ab); end
        exp_bits.delete();
        exp_outcome.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        repeat (5) tick();
        reset_n = 1'b1;
        repeat (50) tick();
        n_checks += 2;
        if ((done_cnt !== d0) || (err_cnt !== e0)) begin
            n_fail++;
            $display("FAIL abort_no_pulse: got done+%0d err+%0d want 0", done_cnt - d0, err_cnt - e0);
        end
        if (tx_if.txReady !== 1'b1) begin n_fail++; $display("FAIL abort_ready_after: got %b want 1", tx_if.txReady); end
        test_frame(8'hA5, "after_abort");
    endtask

    initial begin
        test_reset();
        test_frame(8'hF4, "f4");
        test_frame(8'h00, "x00");
        test_frame(8'hFF, "xff");
        test_timeout();
        test_no_ack();
        test_ignore_start();
        test_reset_mid();
        repeat (10) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
